// File: rtl/ads868x_pkg.sv
// Shared command constants, FSM state type and decode helpers for the
// ADS868x SPI front-end emulator.
package ads868x_pkg;

  localparam logic [15:0] ADS868X_CMD_NO_OP   = 16'h0000;
  localparam logic [15:0] ADS868X_CMD_MAN_CH0 = 16'hC000;
  localparam logic [15:0] ADS868X_CMD_MAN_CH1 = 16'hC400;
  localparam logic [15:0] ADS868X_CMD_MAN_CH2 = 16'hC800;
  localparam logic [15:0] ADS868X_CMD_MAN_CH3 = 16'hCC00;
  localparam logic [15:0] ADS868X_CMD_RST     = 16'h8500;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_DATA,
    S_OVF,
    S_DONE
  } emu_state_t;

  // MAN_CHn words differ only in cmd[11:10], which is the channel number
  function automatic logic is_man_ch(input logic [15:0] c);
    return (c == ADS868X_CMD_MAN_CH0) || (c == ADS868X_CMD_MAN_CH1) ||
           (c == ADS868X_CMD_MAN_CH2) || (c == ADS868X_CMD_MAN_CH3);
  endfunction

  // register ops: cmd[15]=0 and not the all-zero NO_OP word
  function automatic logic is_reg_op(input logic [15:0] c);
    return !c[15] && (c != ADS868X_CMD_NO_OP);
  endfunction

endpackage

// File: rtl/ads868x_emu_sync.sv
// Multi-flop synchronizer for one asynchronous pin, with a selectable
// reset (idle) value so the chain comes out of reset in the pin's idle level.
module ads868x_emu_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // shift the pin level through STAGES flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= {STAGES{RST_VAL}};
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/ads868x_emu.sv
// ADS868x SPI slave emulator: command decode, small register file,
// manual-channel conversion readback and frame status reporting.
module ads868x_emu
  import ads868x_pkg::*;
#(
  parameter int C_SYNC_STAGES = 2,
  parameter int C_REG_AW      = 5
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        SCLK,
  input  logic        CS_N,
  input  logic        SDI,
  output logic        SDO,
  input  logic        RST_PD_N,
  input  logic [63:0] adc_ch_data,
  output logic [15:0] stat_cmd,
  output logic        stat_cmd_valid,
  output logic [1:0]  stat_channel,
  output logic [15:0] stat_frame_cnt,
  output logic        stat_frame_err
);

  localparam int NREG = 2 ** C_REG_AW;

  logic sclk_s, cs_s, sdi_s, rst_pd_s;
  logic sclk_q, cs_q;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  emu_state_t  state;
  logic [5:0]  bit_cnt;
  logic [14:0] shreg;
  logic [15:0] cmd;
  logic [15:0] resp;
  logic        frame_ok;
  logic        blocked;
  logic        sdo;
  logic [15:0] conv_hold;
  logic        man_pending;
  logic [7:0]  regs [NREG];

  logic [15:0] cmd_next;
  logic [6:0]  cmd_addr;
  logic [7:0]  rd_val;
  logic [15:0] resp_next;
  logic [6:0]  done_addr;
  logic [3:0]  bit_idx;

  ads868x_emu_sync #(.STAGES(C_SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(aclk), .rst(areset), .d(SCLK), .q(sclk_s));
  ads868x_emu_sync #(.STAGES(C_SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(aclk), .rst(areset), .d(CS_N), .q(cs_s));
  ads868x_emu_sync #(.STAGES(C_SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
    .clk(aclk), .rst(areset), .d(SDI), .q(sdi_s));
  ads868x_emu_sync #(.STAGES(C_SYNC_STAGES), .RST_VAL(1'b0)) u_sync_pd (
    .clk(aclk), .rst(areset), .d(RST_PD_N), .q(rst_pd_s));

  function automatic logic addr_ok(input logic [6:0] a);
    return (32'(a) >> C_REG_AW) == 32'd0;
  endfunction

  // remember previous synchronized levels for edge detection
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      sclk_q <= 1'b0;
      cs_q   <= 1'b1;
    end else begin
      sclk_q <= sclk_s;
      cs_q   <= cs_s;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign cs_rise   = cs_s & ~cs_q;
  assign cs_fall   = ~cs_s & cs_q;
  assign done_addr = cmd[15:9];
  assign bit_idx   = ~bit_cnt[3:0];
  assign SDO       = sdo & ~cs_s;

  // decode the command word as it completes on the 16th falling edge
  always_comb begin
    cmd_next  = {shreg, sdi_s};
    cmd_addr  = cmd_next[15:9];
    rd_val    = 8'h00;
    resp_next = 16'h0000;
    if (addr_ok(cmd_addr)) rd_val = regs[cmd_addr[C_REG_AW-1:0]];
    if (is_reg_op(cmd_next) && !cmd_next[8]) resp_next = {rd_val, 8'h00};
    else if (man_pending)                    resp_next = conv_hold;
  end

  // frame FSM: bit capture, SDO launch, command execution and status
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state          <= S_IDLE;
      bit_cnt        <= '0;
      shreg          <= '0;
      cmd            <= '0;
      resp           <= '0;
      frame_ok       <= 1'b0;
      blocked        <= 1'b1;
      sdo            <= 1'b0;
      conv_hold      <= '0;
      man_pending    <= 1'b0;
      stat_cmd       <= '0;
      stat_cmd_valid <= 1'b0;
      stat_channel   <= '0;
      stat_frame_cnt <= '0;
      stat_frame_err <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      stat_cmd_valid <= 1'b0;
      stat_frame_err <= 1'b0;
      if (!rst_pd_s) begin
        // power-down: drop everything and wait for a clean CS_N high
        state       <= S_IDLE;
        sdo         <= 1'b0;
        blocked     <= 1'b1;
        conv_hold   <= '0;
        man_pending <= 1'b0;
        for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else begin
        if (cs_s) blocked <= 1'b0;
        case (state)
          S_IDLE: begin
            sdo <= 1'b0;
            if (!blocked && cs_fall) begin
              state   <= S_CMD;
              bit_cnt <= '0;
              shreg   <= '0;
            end
          end
          S_CMD, S_DATA, S_OVF: begin
            // CS_N rise takes priority over any coincident SCLK edge
            if (cs_rise) begin
              state    <= S_DONE;
              frame_ok <= (state == S_DATA);
              sdo      <= 1'b0;
            end else if (sclk_fall && state != S_OVF) begin
              shreg   <= cmd_next[14:0];
              bit_cnt <= bit_cnt + 6'd1;
              if (bit_cnt == 6'd15) begin
                state <= S_DATA;
                cmd   <= cmd_next;
                resp  <= resp_next;
              end
              if (bit_cnt == 6'd32) begin
                state <= S_OVF;
                sdo   <= 1'b0;
              end
            end else if (sclk_rise) begin
              // rising edge k+1 launches frame bit k, k = falling edges so far
              if (state == S_DATA && !bit_cnt[5]) sdo <= resp[bit_idx];
              else                                sdo <= 1'b0;
            end
          end
          S_DONE: begin
            state <= S_IDLE;
            if (frame_ok) begin
              stat_cmd       <= cmd;
              stat_cmd_valid <= 1'b1;
              stat_frame_cnt <= stat_frame_cnt + 16'd1;
              if (cmd == ADS868X_CMD_RST) begin
                conv_hold   <= '0;
                man_pending <= 1'b0;
                for (int i = 0; i < NREG; i++) regs[i] <= '0;
              end else if (is_man_ch(cmd)) begin
                conv_hold    <= adc_ch_data[{cmd[11:10], 4'b0000} +: 16];
                stat_channel <= cmd[11:10];
                man_pending  <= 1'b1;
              end else if (is_reg_op(cmd) && cmd[8] && addr_ok(done_addr)) begin
                regs[done_addr[C_REG_AW-1:0]] <= cmd[7:0];
              end
            end else begin
              stat_frame_err <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ads868x_emu.sv
// Directed bench for ads868x_emu: table of SPI frames with hand-computed
// responses, plus power-down, mid-frame reset and counter-wrap sequences.
module tb_ads868x_emu;

  localparam int HALF = 6;

  logic        aclk = 1'b0;
  logic        areset;
  logic        SCLK, CS_N, SDI, RST_PD_N;
  logic        SDO;
  logic [63:0] adc_ch_data;
  logic [15:0] stat_cmd;
  logic        stat_cmd_valid;
  logic [1:0]  stat_channel;
  logic [15:0] stat_frame_cnt;
  logic        stat_frame_err;

  int tests = 0;
  int fails = 0;
  int valid_seen = 0;
  int err_seen = 0;

  ads868x_emu #(.C_SYNC_STAGES(2), .C_REG_AW(5)) dut (
    .aclk(aclk), .areset(areset), .SCLK(SCLK), .CS_N(CS_N), .SDI(SDI),
    .SDO(SDO), .RST_PD_N(RST_PD_N), .adc_ch_data(adc_ch_data),
    .stat_cmd(stat_cmd), .stat_cmd_valid(stat_cmd_valid),
    .stat_channel(stat_channel), .stat_frame_cnt(stat_frame_cnt),
    .stat_frame_err(stat_frame_err));

  always #5 aclk = ~aclk;

  // count status pulses
  always @(negedge aclk) begin
    if (stat_cmd_valid) valid_seen++;
    if (stat_frame_err) err_seen++;
  end

  typedef struct {
    logic [63:0] data;
    int          n;
    bit          chk_rx;
    logic [15:0] exp_rx;
    bit          acc;
    logic [1:0]  exp_chan;
  } vec_t;

  vec_t vecs [15];

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge aclk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] cmd_of(input logic [63:0] d, input int n);
    return 16'(d >> (n - 16));
  endfunction

  // one CPOL=0/CPHA=1 frame; optional power-down or reset pulse before bit pd_at/ar_at
  task automatic spi_frame(input logic [63:0] data, input int n, input int pd_at,
                           input int ar_at, output logic [15:0] rx16);
    rx16 = 16'h0000;
    @(negedge aclk);
    CS_N = 1'b0;
    wait_cyc(HALF);
    for (int i = 0; i < n; i++) begin
      if (i == pd_at) begin
        RST_PD_N = 1'b0; wait_cyc(10); RST_PD_N = 1'b1; wait_cyc(HALF);
      end
      if (i == ar_at) begin
        areset = 1'b1; wait_cyc(3); areset = 1'b0; wait_cyc(HALF);
      end
      SCLK = 1'b1;
      SDI  = data[n-1-i];
      wait_cyc(HALF);
      if (i >= 16 && i < 32) rx16[31-i] = SDO;
      SCLK = 1'b0;
      wait_cyc(HALF);
    end
    CS_N = 1'b1;
    wait_cyc(12);
  endtask

  logic [15:0] rx;
  logic [15:0] exp_cnt;
  logic [15:0] exp_cmd;
  int v0, e0;

  initial begin
    //         data                 n   chk rx        acc chan
    vecs[0]  = '{64'hC400_0000,     32, 1, 16'h0000, 1, 2'd1};
    vecs[1]  = '{64'h0000_0000,     32, 1, 16'h1234, 1, 2'd1};
    vecs[2]  = '{64'h0B_5A00,       24, 1, 16'h1200, 1, 2'd1};
    vecs[3]  = '{64'h0A_0000,       24, 1, 16'h5A00, 1, 2'd1};
    vecs[4]  = '{64'h123,           12, 1, 16'h0000, 0, 2'd1};
    vecs[5]  = '{64'h0A_0000_0000,  40, 0, 16'h0000, 0, 2'd1};
    vecs[6]  = '{64'h0777,          16, 1, 16'h0000, 1, 2'd1};
    vecs[7]  = '{64'h0600_0000,     32, 1, 16'h7700, 1, 2'd1};
    vecs[8]  = '{64'h8500,          16, 1, 16'h0000, 1, 2'd1};
    vecs[9]  = '{64'h0600_0000,     32, 1, 16'h0000, 1, 2'd1};
    vecs[10] = '{64'h0000_0000,     32, 1, 16'h0000, 1, 2'd1};
    vecs[11] = '{64'hC800,          16, 1, 16'h0000, 1, 2'd2};
    vecs[12] = '{64'h0000_0000,     32, 1, 16'hCCCC, 1, 2'd2};
    vecs[13] = '{64'h4155,          16, 1, 16'h0000, 1, 2'd2};
    vecs[14] = '{64'h4000_0000,     32, 1, 16'h0000, 1, 2'd2};

    areset = 1'b1; SCLK = 1'b0; CS_N = 1'b1; SDI = 1'b0; RST_PD_N = 1'b1;
    adc_ch_data = {16'hDDDD, 16'hCCCC, 16'h1234, 16'hAAAA};
    wait_cyc(5);
    areset = 1'b0;
    wait_cyc(10);

    check("rst_sdo", 32'(SDO), 32'd0);
    check("rst_stat_cmd", 32'(stat_cmd), 32'd0);
    check("rst_valid", 32'(stat_cmd_valid), 32'd0);
    check("rst_channel", 32'(stat_channel), 32'd0);
    check("rst_frame_cnt", 32'(stat_frame_cnt), 32'd0);
    check("rst_frame_err", 32'(stat_frame_err), 32'd0);

    exp_cnt = 16'h0000;
    exp_cmd = 16'h0000;
    for (int k = 0; k < 15; k++) begin
      v0 = valid_seen; e0 = err_seen;
      spi_frame(vecs[k].data, vecs[k].n, -1, -1, rx);
      if (vecs[k].acc) begin
        exp_cnt = exp_cnt + 16'd1;
        exp_cmd = cmd_of(vecs[k].data, vecs[k].n);
      end
      if (vecs[k].chk_rx) check($sformatf("v%0d_sdo", k), 32'(rx), 32'(vecs[k].exp_rx));
      check($sformatf("v%0d_valid", k), 32'(valid_seen - v0), vecs[k].acc ? 32'd1 : 32'd0);
      check($sformatf("v%0d_err", k), 32'(err_seen - e0), vecs[k].acc ? 32'd0 : 32'd1);
      check($sformatf("v%0d_cnt", k), 32'(stat_frame_cnt), 32'(exp_cnt));
      check($sformatf("v%0d_cmd", k), 32'(stat_cmd), 32'(exp_cmd));
      check($sformatf("v%0d_chan", k), 32'(stat_channel), 32'(vecs[k].exp_chan));
    end

    // power-down mid-frame: frame dropped, conversion hold cleared
    v0 = valid_seen; e0 = err_seen;
    spi_frame(64'h0000_0000, 32, 8, -1, rx);
    check("pd_valid", 32'(valid_seen - v0), 32'd0);
    check("pd_err", 32'(err_seen - e0), 32'd0);
    check("pd_cnt", 32'(stat_frame_cnt), 32'(exp_cnt));
    v0 = valid_seen;
    spi_frame(64'h0000_0000, 32, -1, -1, rx);
    exp_cnt = exp_cnt + 16'd1;
    check("pd_next_sdo", 32'(rx), 32'h0000);
    check("pd_next_valid", 32'(valid_seen - v0), 32'd1);
    check("pd_next_cnt", 32'(stat_frame_cnt), 32'(exp_cnt));

    // areset mid-frame: status cleared, rest of frame ignored
    v0 = valid_seen; e0 = err_seen;
    spi_frame(64'hC400, 16, -1, 6, rx);
    check("ar_valid", 32'(valid_seen - v0), 32'd0);
    check("ar_err", 32'(err_seen - e0), 32'd0);
    check("ar_cnt", 32'(stat_frame_cnt), 32'd0);
    check("ar_cmd", 32'(stat_cmd), 32'd0);
    check("ar_chan", 32'(stat_channel), 32'd0);
    spi_frame(64'h0B5A, 16, -1, -1, rx);
    check("ar_next_cnt", 32'(stat_frame_cnt), 32'd1);
    check("ar_next_cmd", 32'(stat_cmd), 32'h0B5A);

    // preload counter near wrap
    @(negedge aclk);
    force dut.stat_frame_cnt = 16'hFFFE;
    @(negedge aclk);
    release dut.stat_frame_cnt;
    spi_frame(64'h0000, 16, -1, -1, rx);
    check("wrap_ffff", 32'(stat_frame_cnt), 32'hFFFF);
    spi_frame(64'h0000, 16, -1, -1, rx);
    check("wrap_zero", 32'(stat_frame_cnt), 32'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ads868x_emu.md
ADS868X_EMU -- requirements
Module: ads868x_emu

Interface
REQ-001 Parameter C_SYNC_STAGES, default 2: synchronizer depth on SCLK/CS_N/SDI/RST_PD_N, range 2..4.
REQ-002 Parameter C_REG_AW, default 5: register-file address width, 2**C_REG_AW 8-bit registers.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset: aclk in 1 (rising edge); areset in 1 (asynchronous assert, active-high).
REQ-004 Pins: SCLK in 1 (CPOL=0); CS_N in 1; SDI in 1 (command from master); SDO out 1 (response, MSB first); RST_PD_N in 1.
REQ-005 adc_ch_data in 64: four 16-bit conversion values, channel n at [16n+15:16n].
REQ-006 stat_cmd out 16 and stat_cmd_valid out 1: decoded command word, one-cycle pulse per accepted frame.
REQ-007 stat_channel out 2: channel of last MAN_CHn command; stat_frame_cnt out 16: accepted-frame count, wraps 0xFFFF->0.
REQ-008 stat_frame_err out 1: one-cycle pulse on a rejected frame (<16 bits or >32 bits).

Function
REQ-009 All pin inputs SHALL pass through C_SYNC_STAGES flops; SCLK/CS_N edges detected on synchronized copies only.
REQ-010 States: S_IDLE (CS_N high), S_CMD (bits 0-15), S_DATA (bits 16-31), S_OVF (>32 falling edges), S_DONE (one cycle after CS_N rise).
REQ-011 CS_N fall: S_IDLE->S_CMD, bit counter=0, SDI shift register cleared; CS_N rise from any active state -> S_DONE -> S_IDLE.
REQ-012 SDI SHALL be sampled on each SCLK falling edge (CPHA=1); counter increments per falling edge; 16th edge -> S_DATA, 33rd edge -> S_OVF.
REQ-013 SDO frame bit k SHALL be launched on SCLK rising edge k+1, within C_SYNC_STAGES+1 aclk of the pin edge; master SCLK half-period >= C_SYNC_STAGES+2 aclk.
REQ-014 SDO SHALL be 0 while CS_N (synchronized) high, in S_OVF, and for frame bits 0-15.
REQ-015 Command decode, performed when bit 15 is sampled: 0x0000 = NO_OP; cmd[15]=1 = device command; else register op, addr=cmd[15:9], W/Rn=cmd[8], wdata=cmd[7:0].
REQ-016 Register read (same frame): bits 16-23 = register value, bits 24-31 = 0; addr >= 2**C_REG_AW reads 0x00.
REQ-017 Register write SHALL take effect in S_DONE only if bit count >= 16; writes to addr >= 2**C_REG_AW are dropped.
REQ-018 MAN_CHn (0xC000/0xC400/0xC800/0xCC00): in S_DONE latch adc_ch_data channel n into conv_hold, stat_channel=n.
REQ-019 Bits 16-31 of any frame following a MAN_CHn frame SHALL carry conv_hold, unless the current frame is a register read (REQ-016 wins).
REQ-020 RST (0x8500): in S_DONE clear register file, conv_hold and MAN-pending flag; other cmd[15]=1 words: accepted, no side effect.
REQ-021 Frames with <16 or >32 falling edges: no decode, no state change, stat_frame_err pulse, stat_frame_cnt unchanged.
REQ-022 Accepted frames (16..32 bits): stat_cmd, stat_cmd_valid pulse and stat_frame_cnt+1 in S_DONE.
REQ-023 RST_PD_N low (synchronized) SHALL clear register file, conv_hold and MAN-pending, force S_IDLE and ignore pins until high and CS_N seen high.
REQ-024 CS_N rise and SCLK edge in the same aclk: the edge is ignored.

Reset
REQ-025 areset SHALL force: state S_IDLE, SDO=0, stat_* outputs 0, counters 0, register file 0, conv_hold 0, MAN-pending 0, sync flops to idle values (CS_N=1, others 0).
REQ-026 Deassertion mid-frame: the frame is ignored until CS_N is seen high.

Structure
REQ-027 ADS868X_CMD_* constants (NO_OP, MAN_CH0..3, RST) and EMU_STATE_T enum SHALL live in ads868x_pkg.
REQ-028 One sub-module, ads868x_emu_sync: per-bit synchronizer with reset value parameter.

Verification
REQ-029 32-bit frame 0xC4000000, then 0x00000000, adc_ch_data[31:16]=0x1234 -> second frame SDO bits 16-31 = 0x1234, stat_channel=1.
REQ-030 24-bit write 0x0B5A00, then 24-bit read 0x0A0000 -> read frame SDO bits 16-23 = 0x5A.
REQ-031 12-bit frame -> stat_frame_err pulse, stat_frame_cnt unchanged; 40-bit frame -> same.
REQ-032 Write reg 0x03=0x77, send 0x8500, read 0x03 -> 0x00.
REQ-033 RST_PD_N low 10 aclk mid-frame -> frame dropped, conv_hold=0, next valid frame accepted.
REQ-034 65536 accepted frames -> stat_frame_cnt wraps to 0x0000.
